float_to_fixed_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754 single-precision to fixed-point converter.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_align_shifter.sv | 26 ++
 rtl/float_to_fixed_pipe.sv | 192 +++++++++++++++++++
 tb/tb_float_to_fixed_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - IEEE-754 single-precision field constants, helpers and rounding modes
package fp_pkg;

    localparam int FP32_EXP_W   = 8;
    localparam int FP32_MANT_W  = 23;
    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    // What stage 1 decided about a sample; only K_NORM goes through align/round.
    typedef enum logic [1:0] {
        K_ZERO,
        K_NAN,
        K_SAT,
        K_NORM
    } fp_kind_e;

    function automatic logic fp_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [FP32_EXP_W-1:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [FP32_MANT_W-1:0] fp_mant(input logic [31:0] f);
        return f[22:0];
    endfunction

    // Round-up decision from the kept LSB, the first dropped bit and the OR of the rest.
    function automatic logic rnd_inc(input logic mode, input logic lsb,
                                     input logic guard, input logic sticky);
        logic inc;
        case (mode)
            RND_TRUNC: inc = 1'b0;
            RND_RNE:   inc = guard & (sticky | lsb);
            default:   inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// rtl/fp_align_shifter.sv - right barrel shift with guard and sticky outputs
module fp_align_shifter #(
    parameter int N  = 24,
    parameter int SW = 5
) (
    input  logic [N-1:0]  data,
    input  logic [SW-1:0] amt,
    output logic [N-1:0]  shifted,
    output logic          guard,
    output logic          sticky
);

    // Zero pad below the data is as wide as the largest shift, so no bit is lost off the end.
    localparam int P = 1 << SW;

    logic [N+P-1:0] wide;

    // Shift the padded word; the pad then holds guard followed by the sticky bits.
    always_comb begin
        wide    = {data, {P{1'b0}}} >> amt;
        shifted = wide[N+P-1:P];
        guard   = wide[P-1];
        sticky  = |wide[P-2:0];
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// rtl/float_to_fixed_pipe.sv - 3-stage float32 to fixed-point converter with stream handshake
module float_to_fixed_pipe
    import fp_pkg::*;
#(
    parameter int INT_BITS  = 1,
    parameter int FRAC_BITS = 20,
    parameter int TWOS_COMP = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_data,
    input  logic                          in_rnd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS:0]   out_data,
    output logic                          out_ovf,
    output logic                          out_udf,
    output logic                          out_inv
);

    localparam int MW     = INT_BITS + FRAC_BITS;       // magnitude width
    localparam int NM     = FP32_MANT_W + 1;            // mantissa with hidden one
    localparam int AW     = ((MW > NM) ? MW : NM) + 1;  // aligned width, room for rounding carry
    localparam int RS_MAX = NM + 2;                     // beyond this every bit is sticky
    localparam int SHW    = 5;
    localparam logic [MW-1:0] MAXMAG = '1;

    logic adv;

    // Stage 1 registers
    logic           s1_valid, s1_sign, s1_rnd, s1_udf;
    fp_kind_e       s1_kind;
    logic [NM-1:0]  s1_mant;
    logic [SHW-1:0] s1_rs;
    logic [7:0]     s1_ls;

    // Stage 2 registers
    logic           s2_valid, s2_sign, s2_rnd, s2_udf, s2_guard, s2_sticky;
    fp_kind_e       s2_kind;
    logic [AW-1:0]  s2_val;

    // Stage 1 combinational
    logic [FP32_EXP_W-1:0]  in_exp;
    logic [FP32_MANT_W-1:0] in_mant;
    int                     sh;
    fp_kind_e               c_kind;
    logic                   c_udf;
    logic [SHW-1:0]         c_rs;
    logic [7:0]             c_ls;

    // Shifter outputs
    logic [NM-1:0] sh_val;
    logic          sh_guard, sh_sticky;

    // Stage 3 combinational
    logic          inc, f_ovf, f_udf, f_inv;
    logic [AW-1:0] sum;
    logic [MW-1:0] mag;
    logic [MW:0]   res;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Classify the float and work out the alignment shift (sh = exponent of the LSB position).
    always_comb begin
        in_exp  = fp_exp(in_data);
        in_mant = fp_mant(in_data);
        sh      = int'(in_exp) - (FP32_BIAS + FP32_MANT_W) + FRAC_BITS;
        c_kind  = K_NORM;
        c_udf   = 1'b0;
        c_rs    = '0;
        c_ls    = '0;
        if (in_exp == '0) begin
            c_kind = K_ZERO;
            c_udf  = (in_mant != '0);
        end else if (in_exp == FP32_EXP_W'(FP32_EXP_MAX)) begin
            c_kind = (in_mant != '0) ? K_NAN : K_SAT;
        end else if (sh > 0) begin
            // Top set bit lands at NM-1+sh; it must stay below MW.
            if (sh >= MW - FP32_MANT_W) c_kind = K_SAT;
            else                        c_ls   = 8'(sh);
        end else if (-sh >= RS_MAX) begin
            c_rs = SHW'(RS_MAX);
        end else begin
            c_rs = SHW'(-sh);
        end
    end

    // Stage 1: register the classification and unpacked mantissa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_udf   <= 1'b0;
            s1_kind  <= K_ZERO;
            s1_mant  <= '0;
            s1_rs    <= '0;
            s1_ls    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sign  <= fp_sign(in_data);
            s1_rnd   <= in_rnd;
            s1_udf   <= c_udf;
            s1_kind  <= c_kind;
            s1_mant  <= {1'b1, in_mant};
            s1_rs    <= c_rs;
            s1_ls    <= c_ls;
        end
    end

    fp_align_shifter #(.N(NM), .SW(SHW)) u_align (
        .data    (s1_mant),
        .amt     (s1_rs),
        .shifted (sh_val),
        .guard   (sh_guard),
        .sticky  (sh_sticky)
    );

    // Stage 2: aligned magnitude; a left shift is exact so guard/sticky are zero then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_rnd    <= 1'b0;
            s2_udf    <= 1'b0;
            s2_kind   <= K_ZERO;
            s2_val    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_rnd    <= s1_rnd;
            s2_udf    <= s1_udf;
            s2_kind   <= s1_kind;
            s2_val    <= AW'(sh_val) << s1_ls;
            s2_guard  <= sh_guard;
            s2_sticky <= sh_sticky;
        end
    end

    // Round, saturate, raise flags and format the output word.
    always_comb begin
        inc   = rnd_inc(s2_rnd, s2_val[0], s2_guard, s2_sticky);
        sum   = s2_val + AW'(inc);
        mag   = '0;
        f_ovf = 1'b0;
        f_udf = 1'b0;
        f_inv = 1'b0;
        case (s2_kind)
            K_ZERO: f_udf = s2_udf;
            K_NAN:  f_inv = 1'b1;
            K_SAT: begin
                mag   = MAXMAG;
                f_ovf = 1'b1;
            end
            default: begin
                if (sum[AW-1:MW] != '0) begin
                    mag   = MAXMAG;
                    f_ovf = 1'b1;
                end else begin
                    mag   = sum[MW-1:0];
                    f_udf = (sum[MW-1:0] == '0);
                end
            end
        endcase
        if (mag == '0)          res = '0;
        else if (TWOS_COMP != 0) res = s2_sign ? -{1'b0, mag} : {1'b0, mag};
        else                     res = {s2_sign, mag};
    end

    // Stage 3: output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_udf   <= 1'b0;
            out_inv   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_data  <= s2_valid ? res : '0;
            out_ovf   <= s2_valid & f_ovf;
            out_udf   <= s2_valid & f_udf;
            out_inv   <= s2_valid & f_inv;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// tb/tb_float_to_fixed_pipe.sv - randomized scoreboard bench for float_to_fixed_pipe
module tb_float_to_fixed_pipe;

    localparam int IB = 1;
    localparam int FB = 20;
    localparam int MW = IB + FB;
    localparam int W  = 1 + MW;
    localparam longint unsigned MAXMAG = (64'd1 << MW) - 1;

    typedef struct packed {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         ovf;
        logic         udf;
        logic         inv;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        r;
        exp_t        e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_rnd, out_ready;
    logic [31:0]  in_data;
    logic         in_ready0, in_ready1, out_valid0, out_valid1;
    logic [W-1:0] out_data0, out_data1;
    logic         ovf0, udf0, inv0, ovf1, udf1, inv1;

    exp_t         q[$];
    exp_t         cur_exp;
    vec_t         dir[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic         held;
    logic [W-1:0] held_d0, held_d1;

    always #5 clk = ~clk;

    float_to_fixed_pipe #(.INT_BITS(IB), .FRAC_BITS(FB), .TWOS_COMP(0)) dut_sm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_rnd(in_rnd), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ovf(ovf0), .out_udf(udf0), .out_inv(inv0)
    );

    float_to_fixed_pipe #(.INT_BITS(IB), .FRAC_BITS(FB), .TWOS_COMP(1)) dut_tc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_rnd(in_rnd), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ovf(ovf1), .out_udf(udf1), .out_inv(inv1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                input logic o, input logic u, input logic i);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.ovf = o; e.udf = u; e.inv = i;
        return e;
    endfunction

    // Exact arithmetic reference: value * 2^FB, then round/saturate by comparison with half an LSB.
    function automatic exp_t model(input logic [31:0] d, input logic r);
        exp_t            e;
        logic            s;
        int              ex, k, n;
        longint unsigned mant, qv, rem, half, mag;
        logic [W-1:0]    m;
        e    = '0;
        s    = d[31];
        ex   = int'(d[30:23]);
        mant = {40'd0, 1'b1, d[22:0]};
        mag  = 0;
        if (ex == 0) begin
            e.udf = (d[22:0] != 0);
        end else if (ex == 255) begin
            if (d[22:0] != 0) e.inv = 1'b1;
            else begin e.ovf = 1'b1; mag = MAXMAG; end
        end else begin
            k = ex - 150 + FB;
            if (k >= 0) begin
                qv = (k > 40) ? MAXMAG + 1 : (mant << k);
            end else begin
                n = -k;
                if (n >= 60) qv = 0;
                else begin
                    qv   = mant >> n;
                    rem  = mant - (qv << n);
                    half = 64'd1 << (n - 1);
                    if (r && (rem > half || (rem == half && qv[0]))) qv = qv + 1;
                end
            end
            if (qv > MAXMAG) begin e.ovf = 1'b1; mag = MAXMAG; end
            else begin mag = qv; e.udf = (qv == 0); end
        end
        m = mag[W-1:0];
        if (mag == 0) begin
            e.d0 = '0; e.d1 = '0;
        end else begin
            e.d0 = {s, m[MW-1:0]};
            e.d1 = s ? (~m + 1'b1) : m;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          sel;
        f   = $urandom;
        sel = $urandom_range(0, 19);
        if (sel == 0)      f[30:23] = 8'd0;
        else if (sel == 1) f[30:23] = 8'd255;
        else if (sel == 2) f[22:0]  = (sel == 2 && $urandom_range(0, 1) == 0) ? 23'd0 : f[22:0];
        if (sel >= 2)      f[30:23] = 8'($urandom_range(95, 132));
        return f;
    endfunction

    task automatic send(input logic [31:0] d, input logic r, input exp_t e);
        int   waitc;
        logic hs;
        waitc    = 0;
        hs       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = r;
        cur_exp  = e;
        while (!hs && waitc < 200) begin
            @(negedge clk);
            hs = in_ready0;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!hs) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] d;
        logic        r;
        d = rand_float();
        r = 1'($urandom_range(0, 1));
        send(d, r, model(d, r));
    endtask

    task automatic drain();
        int c;
        c         = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: pop on output handshake, push on input handshake, verify stall hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                check("stall_hold_sm", 64'(out_data0), 64'(held_d0));
                check("stall_hold_tc", 64'(out_data1), 64'(held_d1));
            end
            if ((out_valid0 || out_valid1) && out_ready) begin
                check("valid_sm", 64'(out_valid0), 64'd1);
                check("valid_tc", 64'(out_valid1), 64'd1);
                if (q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("data_sm", 64'(out_data0), 64'(e.d0));
                    check("data_tc", 64'(out_data1), 64'(e.d1));
                    check("ovf", 64'({ovf0, ovf1}), 64'({e.ovf, e.ovf}));
                    check("udf", 64'({udf0, udf1}), 64'({e.udf, e.udf}));
                    check("inv", 64'({inv0, inv1}), 64'({e.inv, e.inv}));
                end
            end
            if (in_valid && in_ready0) q.push_back(cur_exp);
            held    <= out_valid0 && !out_ready;
            held_d0 <= out_data0;
            held_d1 <= out_data1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;

        dir.push_back('{32'h3F800000, 1'b0, mk(22'h100000, 22'h100000, 0, 0, 0)});
        dir.push_back('{32'hBF000000, 1'b0, mk(22'h280000, 22'h380000, 0, 0, 0)});
        dir.push_back('{32'h40000000, 1'b0, mk(22'h1FFFFF, 22'h1FFFFF, 1, 0, 0)});
        dir.push_back('{32'hFF800000, 1'b0, mk(22'h3FFFFF, 22'h200001, 1, 0, 0)});
        dir.push_back('{32'h7F800000, 1'b1, mk(22'h1FFFFF, 22'h1FFFFF, 1, 0, 0)});
        dir.push_back('{32'h7FC00000, 1'b1, mk(22'h000000, 22'h000000, 0, 0, 1)});
        dir.push_back('{32'h00000001, 1'b1, mk(22'h000000, 22'h000000, 0, 1, 0)});
        dir.push_back('{32'h80000000, 1'b1, mk(22'h000000, 22'h000000, 0, 0, 0)});
        dir.push_back('{32'h35400000, 1'b0, mk(22'h000000, 22'h000000, 0, 1, 0)});
        dir.push_back('{32'h35400000, 1'b1, mk(22'h000001, 22'h000001, 0, 0, 0)});
        dir.push_back('{32'h35000000, 1'b1, mk(22'h000000, 22'h000000, 0, 1, 0)});
        dir.push_back('{32'h35C00000, 1'b1, mk(22'h000002, 22'h000002, 0, 0, 0)});
        dir.push_back('{32'hB5C00000, 1'b1, mk(22'h200002, 22'h3FFFFE, 0, 0, 0)});
        dir.push_back('{32'hBF800000, 1'b0, mk(22'h300000, 22'h300000, 0, 0, 0)});
        dir.push_back('{32'h3FFFFFFF, 1'b1, mk(22'h1FFFFF, 22'h1FFFFF, 1, 0, 0)});
        dir.push_back('{32'h3FFFFFFF, 1'b0, mk(22'h1FFFFF, 22'h1FFFFF, 0, 0, 0)});

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'({out_valid0, out_valid1}), 64'd0);
        check("rst_out_data", 64'({out_data0, out_data1}), 64'd0);
        check("rst_flags", 64'({ovf0, udf0, inv0, ovf1, udf1, inv1}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency of a lone sample, counted from the cycle it is presented.
        send(dir[0].d, dir[0].r, dir[0].e);
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        drain();

        foreach (dir[i]) send(dir[i].d, dir[i].r, dir[i].e);
        drain();

        // Six back-to-back samples with the sink stalled for cycles 2..6.
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", 64'(in_ready0), 64'd0);
                check("bp_out_valid", 64'(out_valid0), 64'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random downstream backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Asynchronous reset with samples in flight.
        for (int i = 0; i < 3; i++) send_rand();
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'({out_valid0, out_valid1}), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_output", 64'({out_valid0, out_valid1}), 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_rand();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
